fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_hold_buf.sv | 34 +++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_stage and fetch_hold_buf.
package fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [4:0]      HALT_OPC = 5'b00000;
  localparam logic [PC_W-1:0] NOP_ENC  = 16'h0800;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_e;

  function automatic logic is_halt(input logic [PC_W-1:0] instr);
    return instr[15:11] == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word while the pipeline is stalled.
// Clear (wrong-path discard) wins over release, and release wins over load.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            release_i,
  input  logic            clear_i,
  input  logic [PC_W-1:0] instr_i,
  output logic [PC_W-1:0] instr_o,
  output logic            valid_o
);

  logic [PC_W-1:0] instr_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_ENC;
      valid_q <= 1'b0;
    end else if (clear_i || release_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a multi-cycle imem and loads IF/ID.
// Optional macro FETCH_ALIGN_CHECK_EN enables the odd-PC fetch error.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [PC_W-1:0] redirect_pc_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic [PC_W-1:0] imem_rdata_in,
  input  logic            imem_done_in,
  output logic [PC_W-1:0] IF_ID_instr_out,
  output logic [PC_W-1:0] IF_ID_pc_plus2_out,
  output logic            IF_ID_valid_out,
  output logic            halt_out,
  output logic            err_out
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] ifid_instr_q;
  logic [PC_W-1:0] ifid_pc2_q;
  logic            ifid_valid_q;
  logic            halt_q;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] hold_instr;
  logic            hold_valid;
  logic            hold_load;
  logic            hold_release;
  logic            align_fault;
  logic            fetching;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign align_fault = (state_q == FETCH) && pc_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (align_fault && !redirect_in) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign align_fault = 1'b0;
  assign err_out     = 1'b0;
`endif

  assign pc_inc   = pc_q + 16'd2;
  assign fetching = ((state_q == FETCH) || (state_q == WAIT)) && !align_fault;

  assign imem_req_out  = !rst && (fetching || (state_q == DRAIN));
  assign imem_addr_out = pc_q;

  assign hold_load    = fetching && imem_done_in && stall_in && !redirect_in;
  assign hold_release = (state_q == HOLD) && !stall_in && !redirect_in;

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hold_load),
    .release_i (hold_release),
    .clear_i   (redirect_in),
    .instr_i   (imem_rdata_in),
    .instr_o   (hold_instr),
    .valid_o   (hold_valid)
  );

  // Redirect beats everything except reset; a still-outstanding response must be drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc2_q   <= '0;
      ifid_valid_q <= 1'b0;
      halt_q       <= 1'b0;
    end else if (redirect_in) begin
      pc_q         <= redirect_pc_in;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      halt_q       <= 1'b0;
      state_q      <= (((state_q == WAIT) || (state_q == DRAIN)) && !imem_done_in)
                      ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH, WAIT: begin
          if (align_fault) begin
            halt_q  <= 1'b1;
            state_q <= HALTED;
            if (!stall_in) begin
              ifid_instr_q <= NOP_INSTR;
              ifid_valid_q <= 1'b0;
            end
          end else if (imem_done_in) begin
            if (stall_in) begin
              state_q <= HOLD;
            end else begin
              ifid_instr_q <= imem_rdata_in;
              ifid_pc2_q   <= pc_inc;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_inc;
              halt_q       <= is_halt(imem_rdata_in);
              state_q      <= is_halt(imem_rdata_in) ? HALTED : FETCH;
            end
          end else begin
            state_q <= WAIT;
            if (!stall_in) begin
              ifid_instr_q <= NOP_INSTR;
              ifid_valid_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall_in && hold_valid) begin
            ifid_instr_q <= hold_instr;
            ifid_pc2_q   <= pc_inc;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_inc;
            halt_q       <= is_halt(hold_instr);
            state_q      <= is_halt(hold_instr) ? HALTED : FETCH;
          end
        end
        DRAIN: begin
          if (imem_done_in) begin
            state_q <= FETCH;
          end
          if (!stall_in) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
        end
        HALTED: begin
          if (!stall_in) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign IF_ID_instr_out    = ifid_instr_q;
  assign IF_ID_pc_plus2_out = ifid_pc2_q;
  assign IF_ID_valid_out    = ifid_valid_q;
  assign halt_out           = halt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table followed by
// randomized traffic compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect_in;
  logic [15:0] redirect_pc_in;
  logic        imem_req_out;
  logic [15:0] imem_addr_out;
  logic [15:0] imem_rdata_in;
  logic        imem_done_in;
  logic [15:0] IF_ID_instr_out;
  logic [15:0] IF_ID_pc_plus2_out;
  logic        IF_ID_valid_out;
  logic        halt_out;
  logic        err_out;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_out       (imem_req_out),
    .imem_addr_out      (imem_addr_out),
    .imem_rdata_in      (imem_rdata_in),
    .imem_done_in       (imem_done_in),
    .IF_ID_instr_out    (IF_ID_instr_out),
    .IF_ID_pc_plus2_out (IF_ID_pc_plus2_out),
    .IF_ID_valid_out    (IF_ID_valid_out),
    .halt_out           (halt_out),
    .err_out            (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  localparam logic [15:0] NOP = 16'h0800;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        done;
    logic [15:0] rdata;
    logic        expReq;
    logic        chkAddr;
    logic [15:0] expAddr;
    logic [15:0] expInstr;
    logic [15:0] expPc2;
    logic        expValid;
    logic        expHalt;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  // Reference model: abstract fetch bookkeeping, not a state machine
  logic [15:0] mPc, mInstr, mPc2, mHeldWord;
  logic        mValid, mHalt, mErr, mHeld, mDrain, mOutstanding;

  task automatic addVec(input logic r, s, rd, input logic [15:0] rp, input logic dn,
                        input logic [15:0] rdat, input logic eReq, cA,
                        input logic [15:0] eAddr, eInstr, ePc2,
                        input logic eValid, eHalt, eErr);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.done = dn; v.rdata = rdat;
    v.expReq = eReq; v.chkAddr = cA; v.expAddr = eAddr;
    v.expInstr = eInstr; v.expPc2 = ePc2; v.expValid = eValid;
    v.expHalt = eHalt; v.expErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, s, rd, input logic [15:0] rp,
                               input logic dn, input logic [15:0] rdat);
    @(negedge clk);
    rst            = r;
    stall_in       = s;
    redirect_in    = rd;
    redirect_pc_in = rp;
    imem_done_in   = dn;
    imem_rdata_in  = rdat;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic modelReq(input logic r);
    return !r && !mHalt && !mHeld && !(ALIGN_ON && mPc[0] && !mOutstanding && !mDrain);
  endfunction

  task automatic deliver(input logic [15:0] w);
    mInstr = w;
    mPc2   = mPc + 16'd2;
    mValid = 1'b1;
    mPc    = mPc + 16'd2;
    if (w[15:11] == 5'b00000) mHalt = 1'b1;
  endtask

  task automatic modelStep(input logic r, s, rd, input logic [15:0] rp,
                           input logic dn, input logic [15:0] rdat);
    logic bubble;
    bubble = 1'b0;
    if (r) begin
      mPc = 16'h0000; mInstr = NOP; mPc2 = 16'h0000; mValid = 1'b0;
      mHalt = 1'b0; mErr = 1'b0; mHeld = 1'b0; mDrain = 1'b0; mOutstanding = 1'b0;
    end else if (rd) begin
      mDrain       = (mOutstanding || mDrain) && !dn;
      mOutstanding = 1'b0;
      mPc          = rp;
      mHeld        = 1'b0;
      mHalt        = 1'b0;
      bubble       = 1'b1;
    end else if (mHalt) begin
      bubble = !s;
    end else if (mDrain) begin
      if (dn) mDrain = 1'b0;
      bubble = !s;
    end else if (mHeld) begin
      if (!s) begin
        deliver(mHeldWord);
        mHeld = 1'b0;
      end
    end else if (ALIGN_ON && mPc[0] && !mOutstanding) begin
      mErr   = 1'b1;
      mHalt  = 1'b1;
      bubble = !s;
    end else if (dn) begin
      mOutstanding = 1'b0;
      if (s) begin
        mHeld     = 1'b1;
        mHeldWord = rdat;
      end else begin
        deliver(rdat);
      end
    end else begin
      mOutstanding = 1'b1;
      bubble       = !s;
    end
    if (bubble) begin
      mInstr = NOP;
      mValid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
    imem_done_in = 1'b0; imem_rdata_in = '0;

    // rst stall redir rpc done rdata | req chkA addr | instr pc2 valid halt err
    addVec(1,0,0,16'h0000,0,16'h0000, 0,0,16'h0000, NOP,16'h0000,0,0,0);
    addVec(1,0,0,16'h0000,0,16'h0000, 0,1,16'h0000, NOP,16'h0000,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4001, 1,1,16'h0000, 16'h4001,16'h0002,1,0,0);
    addVec(0,0,0,16'h0000,1,16'h4002, 1,1,16'h0002, 16'h4002,16'h0004,1,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0004, NOP,16'h0004,0,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0004, NOP,16'h0004,0,0,0);
    addVec(0,1,0,16'h0000,1,16'h4003, 1,1,16'h0004, NOP,16'h0004,0,0,0);
    addVec(0,1,0,16'h0000,0,16'h0000, 0,1,16'h0004, NOP,16'h0004,0,0,0);
    addVec(0,1,0,16'h0000,0,16'h0000, 0,1,16'h0004, NOP,16'h0004,0,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 0,1,16'h0004, 16'h4003,16'h0006,1,0,0);
    addVec(0,0,0,16'h0000,1,16'h0000, 1,1,16'h0006, 16'h0000,16'h0008,1,1,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 0,1,16'h0008, NOP,16'h0008,0,1,0);
    addVec(0,1,0,16'h0000,1,16'h4999, 0,1,16'h0008, NOP,16'h0008,0,1,0);
    addVec(0,0,1,16'h0020,0,16'h0000, 0,1,16'h0008, NOP,16'h0008,0,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0020, NOP,16'h0008,0,0,0);
    addVec(0,0,1,16'h0100,0,16'h0000, 1,1,16'h0020, NOP,16'h0008,0,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0100, NOP,16'h0008,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4444, 1,1,16'h0100, NOP,16'h0008,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4080, 1,1,16'h0100, 16'h4080,16'h0102,1,0,0);
    addVec(0,1,1,16'h0200,1,16'h4555, 1,1,16'h0102, NOP,16'h0102,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4100, 1,1,16'h0200, 16'h4100,16'h0202,1,0,0);
    addVec(0,0,1,16'h0013,0,16'h0000, 1,1,16'h0202, NOP,16'h0202,0,0,0);
`ifdef FETCH_ALIGN_CHECK_EN
    addVec(0,0,0,16'h0000,1,16'h4200, 0,1,16'h0013, NOP,16'h0202,0,1,1);
`else
    addVec(0,0,0,16'h0000,1,16'h4200, 1,1,16'h0013, 16'h4200,16'h0015,1,0,0);
`endif
    addVec(1,0,0,16'h0000,0,16'h0000, 0,0,16'h0000, NOP,16'h0000,0,0,0);
    addVec(0,0,1,16'hFFFE,0,16'h0000, 1,1,16'h0000, NOP,16'h0000,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4300, 1,1,16'hFFFE, 16'h4300,16'h0000,1,0,0);
    addVec(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0000, NOP,16'h0000,0,0,0);
    addVec(1,0,0,16'h0000,1,16'h4777, 0,1,16'h0000, NOP,16'h0000,0,0,0);
    addVec(0,0,0,16'h0000,1,16'h4001, 1,1,16'h0000, 16'h4001,16'h0002,1,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                    vecs[i].done, vecs[i].rdata);
      #1;
      checkOutput($sformatf("vec%0d req", i), {15'b0, imem_req_out}, {15'b0, vecs[i].expReq});
      if (vecs[i].chkAddr)
        checkOutput($sformatf("vec%0d addr", i), imem_addr_out, vecs[i].expAddr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d instr", i), IF_ID_instr_out, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d pc2", i), IF_ID_pc_plus2_out, vecs[i].expPc2);
      checkOutput($sformatf("vec%0d valid", i), {15'b0, IF_ID_valid_out}, {15'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d halt", i), {15'b0, halt_out}, {15'b0, vecs[i].expHalt});
      checkOutput($sformatf("vec%0d err", i), {15'b0, err_out}, {15'b0, vecs[i].expErr});
    end

    $display("[TB] directed table done, starting randomized traffic");

    for (int c = 0; c < 600; c++) begin
      logic        r, s, rd, dn, eReq;
      logic [15:0] rp, rdat;
      r  = (c < 2) || ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 11) == 0);
      rp = 16'($urandom);
      if ($urandom_range(0, 9) != 0) rp[0] = 1'b0;
      rdat = 16'($urandom);
      if ($urandom_range(0, 11) == 0) rdat[15:11] = 5'b00000;
      else if (rdat[15:11] == 5'b00000) rdat[15] = 1'b1;
      eReq = modelReq(r);
      dn   = eReq && ($urandom_range(0, 1) == 1);

      applyStimulus(r, s, rd, rp, dn, rdat);
      #1;
      checkOutput($sformatf("rnd%0d req", c), {15'b0, imem_req_out}, {15'b0, eReq});
      if (eReq)
        checkOutput($sformatf("rnd%0d addr", c), imem_addr_out, mPc);
      @(posedge clk);
      modelStep(r, s, rd, rp, dn, rdat);
      #1;
      checkOutput($sformatf("rnd%0d instr", c), IF_ID_instr_out, mInstr);
      checkOutput($sformatf("rnd%0d pc2", c), IF_ID_pc_plus2_out, mPc2);
      checkOutput($sformatf("rnd%0d valid", c), {15'b0, IF_ID_valid_out}, {15'b0, mValid});
      checkOutput($sformatf("rnd%0d halt", c), {15'b0, halt_out}, {15'b0, mHalt});
      checkOutput($sformatf("rnd%0d err", c), {15'b0, err_out}, {15'b0, mErr});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
